surf_event_merger: RTL and testbench



---
 rtl/surf_event_merger.sv | 148 ++++++++++++++
 tb/tb_surf_event_merger.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/surf_event_merger.sv
// Frame-granular round-robin merger of the per-SURF byte streams
// onto one header-prefixed event stream with truncation and drain.
module surf_event_merger #(
  parameter int NUM_SURF = 7,
  parameter int MAX_LEN  = 1024
) (
  input  logic                  sysclk_i,
  input  logic                  rst_i,
  input  logic [NUM_SURF-1:0]   enable_i,
  input  logic [8*NUM_SURF-1:0] s_surf_tdata,
  input  logic [NUM_SURF-1:0]   s_surf_tvalid,
  input  logic [NUM_SURF-1:0]   s_surf_tlast,
  output logic [NUM_SURF-1:0]   s_surf_tready,
  output logic [7:0]            m_ev_tdata,
  output logic                  m_ev_tvalid,
  output logic                  m_ev_tlast,
  output logic [2:0]            m_ev_tuser,
  input  logic                  m_ev_tready,
  output logic [31:0]           frames_o,
  output logic [15:0]           trunc_count_o
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PASS,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [2:0]          grant_q;
  logic [2:0]          pick;
  logic                hit;
  logic [3:0]          idx;
  logic [4:0]          seq_q;
  logic [15:0]         count_q;
  logic [31:0]         frames_q;
  logic [15:0]         trunc_q;
  logic [NUM_SURF-1:0] cand;
  logic [7:0]          src_data;
  logic                src_valid;
  logic                src_last;
  logic                at_max;
  logic                take;
  logic                fin;

  assign cand      = enable_i & s_surf_tvalid;
  assign src_data  = s_surf_tdata[{grant_q, 3'b000} +: 8];
  assign src_valid = s_surf_tvalid[grant_q];
  assign src_last  = s_surf_tlast[grant_q];
  assign at_max    = (count_q == 16'(MAX_LEN - 1));
  assign fin       = take & (src_last | at_max);

  // First candidate at or after (last grant + 1) mod NUM_SURF
  always_comb begin
    hit  = 1'b0;
    pick = grant_q;
    idx  = '0;
    for (int i = 1; i <= NUM_SURF; i++) begin
      idx = {1'b0, grant_q} + 4'(i);
      if (idx >= 4'(NUM_SURF)) begin
        idx = idx - 4'(NUM_SURF);
      end
      if (!hit && cand[idx[2:0]]) begin
        hit  = 1'b1;
        pick = idx[2:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    s_surf_tready = '0;
    m_ev_tvalid   = 1'b0;
    m_ev_tdata    = '0;
    m_ev_tlast    = 1'b0;
    m_ev_tuser    = '0;
    take          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = HDR;
        end
      end
      HDR: begin
        m_ev_tvalid = 1'b1;
        m_ev_tdata  = {seq_q, grant_q};
        m_ev_tuser  = grant_q;
        if (m_ev_tready) begin
          state_d = PASS;
        end
      end
      PASS: begin
        m_ev_tvalid            = src_valid;
        m_ev_tdata             = src_data;
        m_ev_tlast             = src_last | at_max;
        m_ev_tuser             = grant_q;
        s_surf_tready[grant_q] = m_ev_tready;
        take                   = src_valid & m_ev_tready;
        if (take && (src_last || at_max)) begin
          state_d = src_last ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        s_surf_tready[grant_q] = 1'b1;
        if (src_valid && src_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= 3'd6;
      seq_q    <= '0;
      count_q  <= '0;
      frames_q <= '0;
      trunc_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && hit) begin
        grant_q <= pick;
      end
      if (state_q == HDR && m_ev_tready) begin
        seq_q   <= seq_q + 5'd1;
        count_q <= '0;
      end
      if (take) begin
        count_q <= count_q + 16'd1;
      end
      if (fin) begin
        frames_q <= frames_q + 32'd1;
      end
      // A tlast on the boundary byte is a normal end, not a truncation
      if (take && at_max && !src_last && trunc_q != 16'hFFFF) begin
        trunc_q <= trunc_q + 16'd1;
      end
    end
  end

  assign frames_o      = frames_q;
  assign trunc_count_o = trunc_q;

endmodule

// File: tb/tb_surf_event_merger.sv
// Directed bench for surf_event_merger: frame-level model of the
// merged stream plus literal pins on headers and counters.
module tb_surf_event_merger;

  localparam int MAXL = 8;

  logic        sysclk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [6:0]  enable_i = 7'h7F;
  logic [55:0] s_surf_tdata = '0;
  logic [6:0]  s_surf_tvalid = '0;
  logic [6:0]  s_surf_tlast = '0;
  logic [6:0]  s_surf_tready;
  logic [7:0]  m_ev_tdata;
  logic        m_ev_tvalid;
  logic        m_ev_tlast;
  logic [2:0]  m_ev_tuser;
  logic        m_ev_tready = 1'b1;
  logic [31:0] frames_o;
  logic [15:0] trunc_count_o;

  always #5 sysclk_i = ~sysclk_i;

  surf_event_merger #(.NUM_SURF(7), .MAX_LEN(MAXL)) dut (
    .sysclk_i      (sysclk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .s_surf_tdata  (s_surf_tdata),
    .s_surf_tvalid (s_surf_tvalid),
    .s_surf_tlast  (s_surf_tlast),
    .s_surf_tready (s_surf_tready),
    .m_ev_tdata    (m_ev_tdata),
    .m_ev_tvalid   (m_ev_tvalid),
    .m_ev_tlast    (m_ev_tlast),
    .m_ev_tuser    (m_ev_tuser),
    .m_ev_tready   (m_ev_tready),
    .frames_o      (frames_o),
    .trunc_count_o (trunc_count_o)
  );

  int errors = 0;
  int checks = 0;

  logic [8:0]  srcq [7][$];
  logic [11:0] expq [$];
  logic [7:0]  hdr_log [$];
  int          out_cnt = 0;
  bit          first_flag = 1'b1;
  bit          mon_en = 1'b1;
  bit          bp = 1'b0;
  bit          watch_s0 = 1'b0;
  bit          prev_stall = 1'b0;
  logic [11:0] prev_beat = '0;
  int          mseq = 0;
  int          mframes = 0;
  int          mtrunc = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive_src();
    for (int n = 0; n < 7; n++) begin
      if (srcq[n].size() > 0) begin
        s_surf_tvalid[n]       = 1'b1;
        s_surf_tdata[8*n +: 8] = srcq[n][0][7:0];
        s_surf_tlast[n]        = srcq[n][0][8];
      end else begin
        s_surf_tvalid[n]       = 1'b0;
        s_surf_tdata[8*n +: 8] = 8'h00;
        s_surf_tlast[n]        = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    logic [11:0] beat;
    beat = {m_ev_tuser, m_ev_tlast, m_ev_tdata};
    if (!mon_en) begin
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      chk("stall_hold", 32'({m_ev_tvalid, beat}), 32'({1'b1, prev_beat}));
    end
    if (watch_s0) begin
      chk("s0_ready", 32'(s_surf_tready[0]), 32'd0);
    end
    if (m_ev_tvalid && m_ev_tready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected none", beat);
      end else begin
        chk("beat", 32'(beat), 32'(expq.pop_front()));
      end
      if (first_flag) hdr_log.push_back(m_ev_tdata);
      first_flag = m_ev_tlast;
      out_cnt++;
    end
    prev_stall = m_ev_tvalid && !m_ev_tready;
    prev_beat  = beat;
  endtask

  task automatic step();
    bit take [7];
    @(negedge sysclk_i);
    monitor();
    for (int n = 0; n < 7; n++) begin
      take[n] = s_surf_tvalid[n] && s_surf_tready[n];
    end
    @(posedge sysclk_i);
    #1;
    for (int n = 0; n < 7; n++) begin
      if (take[n] && srcq[n].size() > 0) void'(srcq[n].pop_front());
    end
    drive_src();
    m_ev_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send(input int src, input logic [7:0] pl [$]);
    for (int i = 0; i < pl.size(); i++) begin
      srcq[src].push_back({(i == pl.size() - 1), pl[i]});
    end
    drive_src();
  endtask

  // Expected merged frame: header then payload cut to MAXL bytes
  task automatic frame(input int src, input logic [7:0] pl [$]);
    logic [7:0] hdr;
    int         n;
    hdr = {mseq[4:0], src[2:0]};
    expq.push_back({src[2:0], 1'b0, hdr});
    n = (pl.size() > MAXL) ? MAXL : pl.size();
    for (int i = 0; i < n; i++) begin
      expq.push_back({src[2:0], (i == n - 1), pl[i]});
    end
    mseq++;
    mframes++;
    if (pl.size() > MAXL && mtrunc < 65535) mtrunc++;
    send(src, pl);
  endtask

  function automatic bit srcs_empty(input logic [6:0] ignore);
    for (int n = 0; n < 7; n++) begin
      if (!ignore[n] && srcq[n].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_done(input string name, input logic [6:0] ignore);
    int k = 0;
    while (k < 300 && !(expq.size() == 0 && srcs_empty(ignore))) begin
      step();
      k++;
    end
    if (k >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name,
               expq.size());
    end
    step();
    step();
    chk({name, "_frames"}, frames_o, 32'(mframes));
    chk({name, "_trunc"}, 32'(trunc_count_o), 32'(mtrunc));
  endtask

  task automatic wait_out(input int target);
    int k = 0;
    while (k < 300 && out_cnt < target) begin
      step();
      k++;
    end
    if (out_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL wait_out: got %0d beats expected %0d", out_cnt, target);
    end
  endtask

  task automatic do_reset();
    rst_i  = 1'b1;
    mon_en = 1'b0;
    step();
    rst_i = 1'b0;
    for (int n = 0; n < 7; n++) srcq[n].delete();
    expq.delete();
    mseq       = 0;
    mframes    = 0;
    mtrunc     = 0;
    first_flag = 1'b1;
    prev_stall = 1'b0;
    drive_src();
    mon_en = 1'b1;
    chk("rst_out", 32'({m_ev_tvalid, m_ev_tlast, m_ev_tdata, m_ev_tuser}),
        32'd0);
    chk("rst_ready", 32'(s_surf_tready), 32'd0);
    chk("rst_frames", frames_o, 32'd0);
    chk("rst_trunc", 32'(trunc_count_o), 32'd0);
  endtask

  initial begin
    logic [7:0] pl [$];
    int         hb;
    int         base;

    // Single frame from SURF2
    do_reset();
    hb = hdr_log.size();
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    frame(2, pl);
    wait_done("single", 7'h00);
    chk("single_hdr", 32'(hdr_log[hb]), 32'h02);
    chk("single_frames_lit", frames_o, 32'd1);

    // Round robin from reset: 0, 3, 6, then 0 again
    do_reset();
    hb = hdr_log.size();
    pl = '{8'hA0, 8'hA1};
    frame(0, pl);
    pl = '{8'hB0, 8'hB1};
    frame(3, pl);
    pl = '{8'hC0, 8'hC1};
    frame(6, pl);
    pl = '{8'hD0, 8'hD1};
    frame(0, pl);
    wait_done("rr", 7'h00);
    chk("rr_hdr0", 32'(hdr_log[hb]), 32'h00);
    chk("rr_hdr1", 32'(hdr_log[hb+1]), 32'h0B);
    chk("rr_hdr2", 32'(hdr_log[hb+2]), 32'h16);
    chk("rr_hdr3", 32'(hdr_log[hb+3]), 32'h18);

    // Back-pressure on a 16-byte SURF5 frame (truncated and drained)
    pl = {};
    for (int i = 0; i < 16; i++) pl.push_back(8'(8'h50 + i));
    bp = 1'b1;
    frame(5, pl);
    wait_done("bp", 7'h00);
    bp = 1'b0;
    step();
    chk("bp_frames_lit", frames_o, 32'd5);
    chk("bp_trunc_lit", 32'(trunc_count_o), 32'd1);

    // Truncation of 12 bytes, then an exact-boundary frame
    pl = {};
    for (int i = 0; i < 12; i++) pl.push_back(8'(8'h60 + i));
    frame(1, pl);
    wait_done("trunc", 7'h00);
    chk("trunc_lit", 32'(trunc_count_o), 32'd2);
    pl = {};
    for (int i = 0; i < 8; i++) pl.push_back(8'(8'h70 + i));
    frame(1, pl);
    wait_done("bound", 7'h00);
    chk("bound_trunc_lit", 32'(trunc_count_o), 32'd2);
    chk("bound_frames_lit", frames_o, 32'd7);

    // Enable masking, and disabling mid-frame
    enable_i = 7'b0000010;
    watch_s0 = 1'b1;
    base = out_cnt;
    pl = '{8'h81, 8'h82, 8'h83, 8'h84};
    frame(1, pl);
    pl = '{8'h91, 8'h92};
    send(0, pl);
    wait_out(base + 3);
    enable_i = 7'b0000000;
    wait_done("enable", 7'b0000001);
    watch_s0 = 1'b0;
    chk("enable_s0_left", 32'(srcq[0].size()), 32'd2);
    srcq[0].delete();
    drive_src();
    enable_i = 7'h7F;
    step();

    // Reset while byte 3 of a SURF4 frame is on the output
    base = out_cnt;
    pl = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6};
    frame(4, pl);
    wait_out(base + 3);
    do_reset();
    hb = hdr_log.size();
    pl = '{8'h77, 8'h88};
    frame(2, pl);
    wait_done("post_rst", 7'h00);
    chk("post_rst_hdr", 32'(hdr_log[hb]), 32'h02);
    chk("post_rst_frames_lit", frames_o, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
